multi_clock_divider: RTL and testbench
======================================

// Module: multi_clock_divider
// PURPOSE
//  N-channel runtime-programmable clock divider; next generation of the fixed-ratio divider.
//  Each channel divides clk by 2*(div+1) and provides per-channel enable, a glitch-free
//  divisor change at the period boundary, and a rising-edge tick strobe.
//  A global sync input phase-aligns channels. Feeds ADC modulator, decimator and serial clocks.
// PARAMETERS
//  N_CH        4        number of output channels (1..16)
//  CNT_W       16       divisor/counter width
//  DIV_RESET   16'd167  divisor loaded into every channel at reset
// PORTS
//  clk         in   1          system clock
//  rst         in   1          async active-low reset
//  cfg_we      in   1          divisor write strobe, 1 cycle
//  cfg_ch      in   clog2(N_CH) target channel of write
//  cfg_div     in   CNT_W      new divisor (half-period = cfg_div+1 clk cycles)
//  ch_en       in   N_CH       per-channel run enable (level)
//  sync        in   1          1-cycle phase-align strobe for all enabled channels
//  clk_out     out  N_CH       divided clocks, registered, 50% duty
//  tick        out  N_CH       1-cycle pulse in the cycle clk_out[i] goes 0->1
//  div_pend    out  N_CH       shadow divisor written but not yet active
// BEHAVIOUR
//  Reset (rst=0, async): counters=0, active=shadow=DIV_RESET, clk_out=0, tick=0, div_pend=0.
//  Outputs are always driven after reset deasserts (no tri-state).
//  Counting, when ch_en[i]=1: cnt increments each clk.
//  - When cnt==active_div: cnt<=0, clk_out toggles on the next edge.
//  - Half period = active_div+1 cycles; div=0 gives clk/2.
//  tick[i]=1 for exactly the cycle in which clk_out[i] is first high (registered with clk_out).
//  Config write: cfg_we=1 -> shadow[cfg_ch]<=cfg_div, div_pend[cfg_ch]<=1 next cycle.
//  - cfg_ch>=N_CH: ignored, no state change.
//  - Back-to-back writes to one channel: the last write wins.
//  Divisor commit: active<=shadow, div_pend<=0 only at a full-period boundary.
//  - Boundary = the cycle cnt==active_div while clk_out==1, i.e. the falling toggle.
//  - Never mid-period, so no short or runt pulses.
//  - If the channel is disabled, commit happens on the next cycle.
//  - Write in the same cycle as a boundary commits at the following boundary.
//  Disable (ch_en 1->0):
//  - clk_out high: keeps counting until the falling toggle, then parks at 0 with cnt=0.
//  - clk_out low: parks immediately with cnt held at 0.
//  - No tick while parked.
//  Enable (0->1): cnt starts at 0; first rising toggle after active_div+1 cycles.
//  sync=1: every enabled channel sets cnt<=0 and clk_out<=0.
//  - If clk_out was 1, this falling edge is permitted. It is the sole exception to full-period output.
//  - A pending divisor commits on sync.
//  - All enabled channels then rise together (equal divisors) on the same edge.
//  Simultaneous events: sync has priority over a terminal-count toggle; disable has priority over sync.
//  Reset mid-operation: immediate async clear to reset values; shadow writes are lost.
//  Width rule: cnt is CNT_W bits, compared ==, never wraps because active_div <= 2^CNT_W-1.
// STRUCTURE
//  clkdiv_pkg: CH_W=clog2(N_CH) function, DIV_RESET default, divisor typedef/localparams.
//  clkdiv_channel sub-module: one counter + shadow/active regs + park logic, with ports
//  clk, rst, en, sync, wr, wdiv, clk_out, tick, pend.
//  Top: generate loop of N_CH clkdiv_channel instances plus write-address decode.
// TESTING
//  1 reset release, ch_en=4'b0001, div=167 -> clk_out[0] rises at cycle 168, period 336, tick 1/336.
//  2 div=0 on ch1 -> clk_out[1]=clk/2, tick every 2 cycles; div=2^CNT_W-1 -> period 131072, no wrap glitch.
//  3 write div=3 mid-high-phase of ch0 (div=9) -> current period completes at 10+10;
//    next periods 4+4; div_pend high until commit.
//  4 drop ch_en[2] while high -> low only at terminal count, then stays 0.
//    Drop while low -> parks at once, no tick.
//  5 ch0 div=4, ch1 div=4 out of phase, pulse sync -> both low next cycle, rise together 5 cycles later.
//  6 assert rst mid-count -> all outputs 0 same cycle. cfg_ch=N_CH write -> no div_pend change.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared constants and helpers for the multi-channel clock divider.
//   DEFAULT_N_CH      default number of divider channels
//   DEFAULT_CNT_W     default divisor / counter width
//   DEFAULT_DIV_RESET divisor loaded into every channel at reset
//   ch_w()            width of the channel-select field; at least 1 bit so
//                     that a single-channel build still has a legal port
// -----------------------------------------------------------------------------
package clkdiv_pkg;

    localparam int          DEFAULT_N_CH      = 4;
    localparam int          DEFAULT_CNT_W     = 16;
    localparam logic [15:0] DEFAULT_DIV_RESET = 16'd167;

    function automatic int ch_w(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// -----------------------------------------------------------------------------
// clkdiv_channel
// One divider channel: divides clk by 2*(active_div+1) with a registered,
// 50% duty output, a rising-edge tick, and a shadow divisor that is only
// made active at a full-period boundary (the falling toggle), on sync, or
// while the channel is parked.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   en       in   run enable (level)
//   sync     in   1-cycle phase-align strobe
//   wr       in   1-cycle shadow divisor write strobe
//   wdiv     in   divisor value written on wr
//   clk_out  out  divided clock
//   tick     out  high for the first cycle clk_out is high
//   pend     out  shadow divisor written but not yet active
// Write protocol: wr is a single-cycle strobe with no back-pressure; the
// channel always accepts it and the last write before a commit wins.
// -----------------------------------------------------------------------------
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W     = DEFAULT_CNT_W,
    parameter logic [CNT_W-1:0] DIV_RESET = CNT_W'(DEFAULT_DIV_RESET)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wdiv,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_pend;

    logic             w_terminal;
    logic             w_sync_act;
    logic             w_fall;
    logic             w_parked;
    logic             w_commit;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_clk_nxt;
    logic             w_tick_nxt;

    assign w_terminal = (r_cnt == r_active);
    // Disable outranks sync: a disabled channel ignores the strobe entirely.
    assign w_sync_act = sync && en;
    // The falling toggle is the only full-period boundary. It is reached
    // both while running and while draining a disabled high phase.
    assign w_fall     = r_clk_out && w_terminal;
    assign w_parked   = !en && !r_clk_out;
    // cnt is 0 in every commit case, so a new divisor never sees a count
    // beyond itself and the counter cannot wrap.
    assign w_commit   = r_pend && (w_fall || w_sync_act || w_parked);

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_clk_nxt  = r_clk_out;
        w_tick_nxt = 1'b0;
        if (w_sync_act) begin
            // Sync outranks a terminal-count toggle in the same cycle.
            w_cnt_nxt = '0;
            w_clk_nxt = 1'b0;
        end else if (en) begin
            if (w_terminal) begin
                w_cnt_nxt  = '0;
                w_clk_nxt  = !r_clk_out;
                w_tick_nxt = !r_clk_out;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else if (r_clk_out) begin
            // Disabled mid-high: finish the high phase so no runt pulse
            // appears, then park low.
            if (w_terminal) begin
                w_cnt_nxt = '0;
                w_clk_nxt = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_active  <= DIV_RESET;
            r_shadow  <= DIV_RESET;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
            if (w_commit) begin
                r_active <= r_shadow;
                r_pend   <= 1'b0;
            end
            // A write that coincides with a commit goes to the shadow only
            // and waits for the next boundary; the commit uses the old shadow.
            if (wr) begin
                r_shadow <= wdiv;
                r_pend   <= 1'b1;
            end
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign pend    = r_pend;

endmodule

// File: rtl/multi_clock_divider.sv
// -----------------------------------------------------------------------------
// multi_clock_divider
// N-channel runtime-programmable clock divider. Each channel divides clk by
// 2*(div+1); divisor writes are shadowed and committed glitch-free.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   cfg_we    in   divisor write strobe (1 cycle)
//   cfg_ch    in   target channel of the write; values >= N_CH are ignored
//   cfg_div   in   new divisor (half period = cfg_div+1 clk cycles)
//   ch_en     in   per-channel run enable
//   sync      in   1-cycle phase-align strobe for all enabled channels
//   clk_out   out  divided clocks, registered
//   tick      out  1-cycle pulse in the first high cycle of clk_out[i]
//   div_pend  out  shadow divisor written but not yet active
// -----------------------------------------------------------------------------
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int               N_CH      = DEFAULT_N_CH,
    parameter int               CNT_W     = DEFAULT_CNT_W,
    parameter logic [CNT_W-1:0] DIV_RESET = CNT_W'(DEFAULT_DIV_RESET)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [ch_w(N_CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]        cfg_div,
    input  logic [N_CH-1:0]         ch_en,
    input  logic                    sync,
    output logic [N_CH-1:0]         clk_out,
    output logic [N_CH-1:0]         tick,
    output logic [N_CH-1:0]         div_pend
);

    localparam int CH_W = ch_w(N_CH);

    logic [N_CH-1:0] w_wr;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no instance and are dropped.
        assign w_wr[i] = cfg_we && (cfg_ch == CH_W'(i));

        clkdiv_channel #(
            .CNT_W     (CNT_W),
            .DIV_RESET (DIV_RESET)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[i]),
            .sync    (sync),
            .wr      (w_wr[i]),
            .wdiv    (cfg_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (div_pend[i])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_multi_clock_divider
// Directed bench for multi_clock_divider. Three channels so that cfg_ch=3 is
// an out-of-range channel; an 8-bit counter so the all-ones divisor gives a
// short full-width period. Inputs change and outputs are sampled on the
// falling edge of clk.
// -----------------------------------------------------------------------------
module tb_multi_clock_divider;

    localparam int N_CH  = 3;
    localparam int CNT_W = 8;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [N_CH-1:0]  ch_en;
    logic             sync;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  div_pend;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    multi_clock_divider #(
        .N_CH      (N_CH),
        .CNT_W     (CNT_W),
        .DIV_RESET (8'd167)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .ch_en    (ch_en),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_pend (div_pend)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_sb(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed %0d expected <empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_div = d;
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    // Cycles until clk_out[ch] reaches level val; -1 if the budget runs out.
    task automatic wait_edge(input int ch, input logic val, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (clk_out[ch] !== val && n < budget);
        if (clk_out[ch] !== val) n = -1;
    endtask

    // Expected interval is queued before the wait, popped when the edge arrives.
    task automatic measure(input string tag, input int ch, input logic val, input int exp_n);
        int n;
        exp_q.push_back(32'(exp_n));
        wait_edge(ch, val, 600, n);
        check_sb(tag, 32'(n));
    endtask

    task automatic count_window(input int ch, input int cycles, output int ticks, output int highs);
        ticks = 0;
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tick[ch] === 1'b1) ticks++;
            if (clk_out[ch] === 1'b1) highs++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        int h;
        int n;

        rst     = 1'b1;
        cfg_we  = 1'b0;
        cfg_ch  = '0;
        cfg_div = '0;
        ch_en   = 3'b001;
        sync    = 1'b0;
        #1 rst  = 1'b0;
        repeat (3) step();
        check("reset_clk_out", 32'(clk_out), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_pend", 32'(div_pend), 32'd0);

        // 1: default divisor 167 -> rise after 168, period 336, one tick per period
        rst = 1'b1;
        measure("t1_first_rise", 0, 1'b1, 168);
        check("t1_tick_at_rise", 32'(tick[0]), 32'd1);
        check("t1_others_idle", 32'(clk_out[2:1]), 32'd0);
        count_window(0, 336, t, h);
        check("t1_ticks_per_period", 32'(t), 32'd1);
        check("t1_high_cycles", 32'(h), 32'd168);
        check("t1_high_after_period", 32'(clk_out[0]), 32'd1);
        measure("t1_fall", 0, 1'b0, 168);
        ch_en[0] = 1'b0;

        // 3: shadow commit while parked, then mid-high write of 3 over 9
        cfg_write(0, 8'd9);
        check("t3_pend_parked", 32'(div_pend[0]), 32'd1);
        step();
        check("t3_commit_parked", 32'(div_pend[0]), 32'd0);
        ch_en[0] = 1'b1;
        measure("t3_rise_div9", 0, 1'b1, 10);
        repeat (3) step();
        cfg_write(0, 8'd3);
        check("t3_pend_midhigh", 32'(div_pend[0]), 32'd1);
        measure("t3_high_completes", 0, 1'b0, 6);
        check("t3_commit_at_fall", 32'(div_pend[0]), 32'd0);
        measure("t3_low_div3", 0, 1'b1, 4);
        measure("t3_high_div3", 0, 1'b0, 4);
        measure("t3_low2_div3", 0, 1'b1, 4);

        // 2: div=0 -> clk/2, then all-ones divisor written on a boundary cycle
        cfg_write(1, 8'd0);
        check("t2_pend_set", 32'(div_pend[1]), 32'd1);
        step();
        check("t2_pend_clear", 32'(div_pend[1]), 32'd0);
        ch_en[1] = 1'b1;
        measure("t2_first_rise_div0", 1, 1'b1, 1);
        check("t2_tick_div0", 32'(tick[1]), 32'd1);
        count_window(1, 8, t, h);
        check("t2_ticks_div0", 32'(t), 32'd4);
        cfg_write(1, 8'd255);
        check("t2_fall_on_write", 32'(clk_out[1]), 32'd0);
        check("t2_pend_max", 32'(div_pend[1]), 32'd1);
        measure("t2_old_div_rise", 1, 1'b1, 1);
        measure("t2_old_div_fall", 1, 1'b0, 1);
        check("t2_commit_max", 32'(div_pend[1]), 32'd0);
        measure("t2_low_max", 1, 1'b1, 256);
        check("t2_tick_max", 32'(tick[1]), 32'd1);
        measure("t2_high_max", 1, 1'b0, 256);
        ch_en[1] = 1'b0;

        // 4: disable while high drains to terminal count; while low parks at once
        cfg_write(2, 8'd5);
        step();
        ch_en[2] = 1'b1;
        measure("t4_rise", 2, 1'b1, 6);
        repeat (2) step();
        ch_en[2] = 1'b0;
        measure("t4_drain_fall", 2, 1'b0, 4);
        count_window(2, 20, t, h);
        check("t4_parked_ticks", 32'(t), 32'd0);
        check("t4_parked_high", 32'(h), 32'd0);
        ch_en[2] = 1'b1;
        measure("t4_rise2", 2, 1'b1, 6);
        measure("t4_fall2", 2, 1'b0, 6);
        repeat (2) step();
        ch_en[2] = 1'b0;
        count_window(2, 20, t, h);
        check("t4_low_park_ticks", 32'(t), 32'd0);
        check("t4_low_park_high", 32'(h), 32'd0);
        ch_en[2] = 1'b1;
        measure("t4_restart_from_zero", 2, 1'b1, 6);
        ch_en[2] = 1'b0;
        measure("t4_drain_full_high", 2, 1'b0, 6);

        // 5: two div=4 channels out of phase, sync aligns them
        cfg_write(1, 8'd4);
        cfg_write(0, 8'd4);
        wait_edge(0, 1'b1, 600, n);
        wait_edge(0, 1'b0, 600, n);
        measure("t5_ch0_div4_low", 0, 1'b1, 5);
        repeat (2) step();
        ch_en[1] = 1'b1;
        repeat (7) step();
        check("t5_out_of_phase", 32'(clk_out[1:0]), 32'd2);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("t5_sync_low", 32'(clk_out[1:0]), 32'd0);
        check("t5_sync_no_tick", 32'(tick[1:0]), 32'd0);
        measure("t5_aligned_rise", 0, 1'b1, 5);
        check("t5_ch1_rises_too", 32'(clk_out[1]), 32'd1);
        check("t5_both_tick", 32'(tick[1:0]), 32'd3);
        cfg_write(0, 8'd1);
        check("t5_pend_before_sync", 32'(div_pend[0]), 32'd1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("t5_commit_on_sync", 32'(div_pend[0]), 32'd0);
        check("t5_sync_from_high", 32'(clk_out[1:0]), 32'd0);
        measure("t5_new_div_rise", 0, 1'b1, 2);

        // 6: async reset mid-count, then out-of-range channel write
        cfg_write(1, 8'd7);
        check("t6_pend_before_rst", 32'(div_pend[1]), 32'd1);
        check("t6_high_before_rst", 32'(clk_out[0]), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_clk_out", 32'(clk_out), 32'd0);
        check("t6_rst_tick", 32'(tick), 32'd0);
        check("t6_rst_pend", 32'(div_pend), 32'd0);
        step();
        rst = 1'b1;
        cfg_write(2'd3, 8'd5);
        check("t6_bad_ch_no_pend", 32'(div_pend), 32'd0);
        measure("t6_default_div_back", 0, 1'b1, 167);
        check("t6_ch1_default_div", 32'(clk_out[1]), 32'd1);
        check("t6_ticks_after_rst", 32'(tick), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
